reg_dump_tx: RTL and testbench

Debug read-out engine for the 32×32 register file. On a start pulse it walks the register file's debug read port (`reg_out_id`/`reg_out_data`) from register 0 to `LAST_REG`. It captures each word and transmits the whole dump as an 8N1 UART byte stream on `txd`. It sits beside the register file and drives its debug port, replacing a 1024-bit parallel bus with a single-pin serial dump.

---
 rtl/reg_dump_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_reg_dump_tx.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: debug read-out engine for the 32x32 register file.
// Walks the debug read port from register 0 to LAST_REG and sends a sync
// byte followed by every captured word (big-endian) as an 8N1 UART stream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | txd high, waiting for start
// S_SYNC  | shifting out the 0xA5 sync byte
// S_FETCH | one idle-high cycle, word captured from reg_out_data
// S_SEND  | shifting out the 4 bytes of the captured word
// S_DONE  | one-cycle done pulse, back to idle

module reg_dump_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int LAST_REG     = 31
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic [4:0]  reg_out_id,
   input  logic [31:0] reg_out_data,
   output logic        txd,
   output logic        busy,
   output logic        done
);

   // Bit-time counter is a down-counter reloaded at every bit boundary.
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [4:0]    LAST_ID    = 5'(LAST_REG);
   localparam logic [3:0]    START_BIT  = 4'd0;
   localparam logic [3:0]    STOP_BIT   = 4'd9;
   localparam logic [1:0]    LAST_BYTE  = 2'd3;
   localparam logic [7:0]    SYNC_BYTE  = 8'hA5;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SYNC  = 3'd1;
   localparam logic [2:0] S_FETCH = 3'd2;
   localparam logic [2:0] S_SEND  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state_q,    state_d;
   logic [CW-1:0] bit_cnt_q,  bit_cnt_d;
   logic [3:0]    bit_idx_q,  bit_idx_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [4:0]    reg_id_q,   reg_id_d;
   logic [31:0]   word_q,     word_d;

   logic       bit_end;
   logic       byte_end;
   logic       shifting;
   logic [7:0] tx_byte;
   logic [2:0] data_sel;
   logic       frame_bit;

   assign bit_end  = (bit_cnt_q == '0);
   assign byte_end = bit_end && (bit_idx_q == STOP_BIT);
   assign shifting = (state_q == S_SYNC) || (state_q == S_SEND);

   // State sequencing: the stop bit of the last byte of a phase decides where to go.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SYNC;
            end
         end
         S_SYNC: begin
            if (byte_end) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_SEND;
         end
         S_SEND: begin
            if (byte_end && (byte_idx_q == LAST_BYTE)) begin
               if (reg_id_q == LAST_ID) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bit timer: reloaded on entry to a byte and at every bit boundary, never wraps.
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               bit_cnt_d = BIT_RELOAD;
            end
         end
         S_FETCH: begin
            bit_cnt_d = BIT_RELOAD;
         end
         S_SYNC, S_SEND: begin
            if (bit_end) begin
               bit_cnt_d = BIT_RELOAD;
            end else begin
               bit_cnt_d = bit_cnt_q - 1'b1;
            end
         end
         default: begin
            bit_cnt_d = bit_cnt_q;
         end
      endcase
   end

   // Bit index within a byte: 0 is the start bit, 9 the stop bit.
   always_comb begin
      bit_idx_d = bit_idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               bit_idx_d = START_BIT;
            end
         end
         S_FETCH: begin
            bit_idx_d = START_BIT;
         end
         S_SYNC, S_SEND: begin
            if (bit_end) begin
               if (bit_idx_q == STOP_BIT) begin
                  bit_idx_d = START_BIT;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         default: begin
            bit_idx_d = bit_idx_q;
         end
      endcase
   end

   // Byte index within the current word; cleared at FETCH, advanced after each stop bit.
   always_comb begin
      byte_idx_d = byte_idx_q;
      if (state_q == S_FETCH) begin
         byte_idx_d = 2'd0;
      end else if ((state_q == S_SEND) && byte_end && (byte_idx_q != LAST_BYTE)) begin
         byte_idx_d = byte_idx_q + 1'b1;
      end
   end

   // Register address: cleared on start, held through FETCH/SEND, stepped only below LAST_REG.
   always_comb begin
      reg_id_d = reg_id_q;
      if ((state_q == S_IDLE) && start) begin
         reg_id_d = 5'd0;
      end else if ((state_q == S_SEND) && byte_end && (byte_idx_q == LAST_BYTE) &&
                   (reg_id_q != LAST_ID)) begin
         reg_id_d = reg_id_q + 1'b1;
      end
   end

   // Word snapshot: reg_out_data is only looked at on the FETCH closing edge.
   always_comb begin
      word_d = word_q;
      if (state_q == S_FETCH) begin
         word_d = reg_out_data;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         bit_idx_q  <= START_BIT;
         byte_idx_q <= 2'd0;
         reg_id_q   <= 5'd0;
         word_q     <= 32'd0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         reg_id_q   <= reg_id_d;
         word_q     <= word_d;
      end
   end

   // Byte currently on the line: sync byte, or the word most significant byte first.
   always_comb begin
      tx_byte = SYNC_BYTE;
      if (state_q == S_SEND) begin
         case (byte_idx_q)
            2'd0:    tx_byte = word_q[31:24];
            2'd1:    tx_byte = word_q[23:16];
            2'd2:    tx_byte = word_q[15:8];
            default: tx_byte = word_q[7:0];
         endcase
      end
   end

   assign data_sel = 3'(bit_idx_q - 4'd1);

   // Frame bit: start 0, data LSB first, stop 1.
   always_comb begin
      frame_bit = 1'b1;
      if (bit_idx_q == START_BIT) begin
         frame_bit = 1'b0;
      end else if (bit_idx_q < STOP_BIT) begin
         frame_bit = tx_byte[data_sel];
      end
   end

   // Outputs decode straight from state so reset forces them immediately.
   assign txd        = shifting ? frame_bit : 1'b1;
   assign busy       = shifting || (state_q == S_FETCH);
   assign done       = (state_q == S_DONE);
   assign reg_out_id = reg_id_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: two instances (full 32-register dump and a
// 3-register dump) each with a UART receiver feeding a byte scoreboard.

module tb_reg_dump_tx;

   localparam int CPB      = 4;
   localparam int BYTE_CYC = 10 * CPB;
   localparam int FULL_BUSY  = 10 * CPB * (1 + 4 * 32) + 32;
   localparam int SHORT_BUSY = 10 * CPB * (1 + 4 * 3) + 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start0, start1;
   logic [4:0]  id0, id1;
   logic [31:0] rdata0, rdata1;
   logic [1:0]  txd_w, busy_w, done_w;
   logic [31:0] regs0[32];
   logic [31:0] regs1[32];

   assign rdata0 = regs0[id0];
   assign rdata1 = regs1[id1];

   reg_dump_tx #(.CLKS_PER_BIT(CPB), .LAST_REG(31)) dut0 (
      .clock(clk), .reset(rst_n), .start(start0), .reg_out_id(id0),
      .reg_out_data(rdata0), .txd(txd_w[0]), .busy(busy_w[0]), .done(done_w[0]));

   reg_dump_tx #(.CLKS_PER_BIT(CPB), .LAST_REG(2)) dut1 (
      .clock(clk), .reset(rst_n), .start(start1), .reg_out_id(id1),
      .reg_out_data(rdata1), .txd(txd_w[1]), .busy(busy_w[1]), .done(done_w[1]));

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   logic [7:0] rx_q0[$];
   logic [7:0] rx_q1[$];
   int         gap_q0[$];

   // UART receiver / activity monitor state, owned by the monitor process.
   logic       m_act[2]    = '{1'b0, 1'b0};
   logic       m_bv[2]     = '{1'b1, 1'b1};
   logic [7:0] m_sh[2]     = '{8'h00, 8'h00};
   int         m_cnt[2]    = '{0, 0};
   int         m_gap[2]    = '{0, 0};
   int         viol[2]     = '{0, 0};
   int         busy_run[2] = '{0, 0};
   int         busy_len[2] = '{0, 0};
   int         done_cnt[2] = '{0, 0};
   int         max_id[2]   = '{0, 0};

   // Decode txd into bytes, flag any level that does not hold a full bit time.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            m_act[d]    = 1'b0;
            m_gap[d]    = 0;
            busy_run[d] = 0;
         end else begin
            if (busy_w[d]) busy_run[d]++;
            if (done_w[d]) begin
               done_cnt[d]++;
               busy_len[d] = busy_run[d];
            end
            if (!busy_w[d]) busy_run[d] = 0;
            if (d == 0 && int'(id0) > max_id[0]) max_id[0] = int'(id0);
            if (d == 1 && int'(id1) > max_id[1]) max_id[1] = int'(id1);
            if (!m_act[d]) begin
               if (txd_w[d] === 1'b0) begin
                  m_act[d] = 1'b1;
                  m_cnt[d] = 0;
                  m_bv[d]  = 1'b0;
                  if (d == 0) gap_q0.push_back(m_gap[d]);
               end else begin
                  m_gap[d]++;
               end
            end else begin
               m_cnt[d]++;
               if (m_cnt[d] % CPB == 0) m_bv[d] = txd_w[d];
               else if (txd_w[d] !== m_bv[d]) viol[d]++;
               if (m_cnt[d] / CPB >= 1 && m_cnt[d] / CPB <= 8 && m_cnt[d] % CPB == CPB / 2)
                  m_sh[d] = {txd_w[d], m_sh[d][7:1]};
               if (m_cnt[d] == BYTE_CYC - 1) begin
                  if (m_bv[d] !== 1'b1) viol[d]++;
                  if (d == 0) rx_q0.push_back(m_sh[d]);
                  else        rx_q1.push_back(m_sh[d]);
                  m_act[d] = 1'b0;
                  m_gap[d] = 0;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input int d);
      if (d == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      if (d == 0) start0 = 1'b0; else start1 = 1'b0;
   endtask

   task automatic wait_done(input int d, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_w[d] === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_id0(input logic [4:0] v, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (id0 === v) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic preload0();
      for (int i = 0; i < 32; i++) regs0[i] = 32'h0100_0000 * i + i;
   endtask

   task automatic push_exp0(input int last);
      exp_q0.push_back(8'hA5);
      for (int i = 0; i <= last; i++) begin
         exp_q0.push_back(regs0[i][31:24]);
         exp_q0.push_back(regs0[i][23:16]);
         exp_q0.push_back(regs0[i][15:8]);
         exp_q0.push_back(regs0[i][7:0]);
      end
   endtask

   task automatic flush0();
      rx_q0.delete();
      gap_q0.delete();
      exp_q0.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
      tick(3);
      for (int d = 0; d < 2; d++) begin
         n_vec++; if (txd_w[d] !== 1'b1) begin n_err++; $display("FAIL reset_txd%0d: got %b required 1", d, txd_w[d]); end
         n_vec++; if (busy_w[d] !== 1'b0) begin n_err++; $display("FAIL reset_busy%0d: got %b required 0", d, busy_w[d]); end
         n_vec++; if (done_w[d] !== 1'b0) begin n_err++; $display("FAIL reset_done%0d: got %b required 0", d, done_w[d]); end
      end
      n_vec++; if (id0 !== 5'd0) begin n_err++; $display("FAIL reset_id0: got %0d required 0", id0); end
      n_vec++; if (id1 !== 5'd0) begin n_err++; $display("FAIL reset_id1: got %0d required 0", id1); end
      rst_n = 1'b1;
      tick(3);
      n_vec++; if (busy_w !== 2'b00 || txd_w !== 2'b11) begin
         n_err++; $display("FAIL idle_after_reset: got busy=%b txd=%b required busy=00 txd=11", busy_w, txd_w);
      end
   endtask

   task automatic test_nominal();
      bit ok;
      int base, idle_bad, b, g;
      logic [7:0] e, r;
      preload0(); flush0(); push_exp0(31);
      base = done_cnt[0];
      pulse_start(0);
      n_vec++; if (busy_w[0] !== 1'b1 || txd_w[0] !== 1'b0) begin
         n_err++; $display("FAIL nominal_first_edge: got busy=%b txd=%b required busy=1 txd=0", busy_w[0], txd_w[0]);
      end
      wait_done(0, 6000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL nominal_done_timeout: got no done required done"); end
      tick(2);
      n_vec++; if (busy_len[0] !== FULL_BUSY) begin n_err++; $display("FAIL nominal_busy_len: got %0d required %0d", busy_len[0], FULL_BUSY); end
      n_vec++; if (done_cnt[0] - base !== 1) begin n_err++; $display("FAIL nominal_done_count: got %0d required 1", done_cnt[0] - base); end
      n_vec++; if (done_w[0] !== 1'b0) begin n_err++; $display("FAIL nominal_done_width: got %b required 0", done_w[0]); end
      n_vec++; if (rx_q0.size() != 129) begin n_err++; $display("FAIL nominal_byte_count: got %0d required 129", rx_q0.size()); end
      b = 0;
      while (exp_q0.size() > 0) begin
         e = exp_q0.pop_front();
         n_vec++;
         if (rx_q0.size() == 0) begin n_err++; $display("FAIL nominal_byte%0d: got none required %02h", b, e); end
         else begin
            r = rx_q0.pop_front();
            if (r !== e) begin n_err++; $display("FAIL nominal_byte%0d: got %02h required %02h", b, r, e); end
         end
         if (gap_q0.size() > 0) begin
            g = gap_q0.pop_front();
            if (b > 0) begin
               n_vec++;
               if (g != (((b - 1) % 4 == 0) ? 1 : 0)) begin
                  n_err++; $display("FAIL nominal_gap%0d: got %0d required %0d", b, g, ((b - 1) % 4 == 0) ? 1 : 0);
               end
            end
         end
         b++;
      end
      idle_bad = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) idle_bad++;
      end
      n_vec++; if (idle_bad != 0) begin n_err++; $display("FAIL nominal_idle_txd: got %0d bad cycles required 0", idle_bad); end
      n_vec++; if (viol[0] != 0) begin n_err++; $display("FAIL nominal_bit_timing: got %0d violations required 0", viol[0]); end
   endtask

   task automatic test_short();
      bit ok;
      logic [7:0] e, r;
      logic [7:0] bytes[13] = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34,
                                8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < 32; i++) regs1[i] = 32'h5555_0000 + i;
      regs1[0] = 32'hDEAD_BEEF; regs1[1] = 32'h1234_5678; regs1[2] = 32'hFFFF_FFFF;
      rx_q1.delete(); exp_q1.delete();
      foreach (bytes[i]) exp_q1.push_back(bytes[i]);
      pulse_start(1);
      wait_done(1, 1000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL short_done_timeout: got no done required done"); end
      tick(2);
      n_vec++; if (rx_q1.size() != 13) begin n_err++; $display("FAIL short_byte_count: got %0d required 13", rx_q1.size()); end
      for (int b = 0; exp_q1.size() > 0; b++) begin
         e = exp_q1.pop_front();
         n_vec++;
         if (rx_q1.size() == 0) begin n_err++; $display("FAIL short_byte%0d: got none required %02h", b, e); end
         else begin
            r = rx_q1.pop_front();
            if (r !== e) begin n_err++; $display("FAIL short_byte%0d: got %02h required %02h", b, r, e); end
         end
      end
      n_vec++; if (max_id[1] != 2) begin n_err++; $display("FAIL short_max_id: got %0d required 2", max_id[1]); end
      n_vec++; if (busy_len[1] != SHORT_BUSY) begin n_err++; $display("FAIL short_busy_len: got %0d required %0d", busy_len[1], SHORT_BUSY); end
      n_vec++; if (viol[1] != 0) begin n_err++; $display("FAIL short_bit_timing: got %0d violations required 0", viol[1]); end
   endtask

   task automatic test_start_while_busy();
      bit ok;
      int base;
      logic [7:0] e, r;
      preload0(); flush0(); push_exp0(31);
      base = done_cnt[0];
      pulse_start(0);
      wait_id0(5'd5, 2000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL swb_reach_reg5: got id %0d required 5", id0); end
      tick(20);
      pulse_start(0);
      wait_done(0, 6000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL swb_done_timeout: got no done required done"); end
      tick(4);
      n_vec++; if (done_cnt[0] - base != 1) begin n_err++; $display("FAIL swb_done_count: got %0d required 1", done_cnt[0] - base); end
      n_vec++; if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL swb_no_requeue: got busy=%b required 0", busy_w[0]); end
      n_vec++; if (rx_q0.size() != 129) begin n_err++; $display("FAIL swb_byte_count: got %0d required 129", rx_q0.size()); end
      for (int b = 0; exp_q0.size() > 0; b++) begin
         e = exp_q0.pop_front();
         n_vec++;
         if (rx_q0.size() == 0) begin n_err++; $display("FAIL swb_byte%0d: got none required %02h", b, e); end
         else begin
            r = rx_q0.pop_front();
            if (r !== e) begin n_err++; $display("FAIL swb_byte%0d: got %02h required %02h", b, r, e); end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int base, lat;
      logic [7:0] e, r;
      preload0(); flush0(); push_exp0(31); push_exp0(31);
      base = done_cnt[0];
      start0 = 1'b1;
      wait_done(0, 6000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_first_done_timeout: got no done required done"); end
      lat = 0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (busy_w[0] === 1'b1) begin lat = i; break; end
      end
      start0 = 1'b0;
      n_vec++; if (lat != 2) begin n_err++; $display("FAIL b2b_restart_latency: got %0d required 2", lat); end
      wait_done(0, 6000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_second_done_timeout: got no done required done"); end
      tick(4);
      n_vec++; if (done_cnt[0] - base != 2) begin n_err++; $display("FAIL b2b_done_count: got %0d required 2", done_cnt[0] - base); end
      n_vec++; if (rx_q0.size() != 258) begin n_err++; $display("FAIL b2b_byte_count: got %0d required 258", rx_q0.size()); end
      for (int b = 0; exp_q0.size() > 0; b++) begin
         e = exp_q0.pop_front();
         n_vec++;
         if (rx_q0.size() == 0) begin n_err++; $display("FAIL b2b_byte%0d: got none required %02h", b, e); end
         else begin
            r = rx_q0.pop_front();
            if (r !== e) begin n_err++; $display("FAIL b2b_byte%0d: got %02h required %02h", b, r, e); end
         end
      end
   endtask

   task automatic test_snapshot();
      bit ok;
      logic [31:0] keep;
      logic [7:0] e, r;
      // Write landing during reg 3's FETCH cycle must be the value sent.
      preload0(); flush0();
      keep = regs0[3]; regs0[3] = 32'hCAFE_F00D; push_exp0(31); regs0[3] = keep;
      pulse_start(0);
      wait_id0(5'd3, 2000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL snap_reach_reg3: got id %0d required 3", id0); end
      regs0[3] = 32'hCAFE_F00D;
      wait_done(0, 6000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL snap_done_timeout: got no done required done"); end
      tick(2);
      // Write during reg 3's SEND must not change what goes out.
      push_exp0(31);
      pulse_start(0);
      wait_id0(5'd3, 2000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL snap2_reach_reg3: got id %0d required 3", id0); end
      tick(3);
      regs0[3] = 32'h1111_2222;
      wait_done(0, 6000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL snap2_done_timeout: got no done required done"); end
      tick(2);
      n_vec++; if (rx_q0.size() != 258) begin n_err++; $display("FAIL snap_byte_count: got %0d required 258", rx_q0.size()); end
      for (int b = 0; exp_q0.size() > 0; b++) begin
         e = exp_q0.pop_front();
         n_vec++;
         if (rx_q0.size() == 0) begin n_err++; $display("FAIL snap_byte%0d: got none required %02h", b, e); end
         else begin
            r = rx_q0.pop_front();
            if (r !== e) begin n_err++; $display("FAIL snap_byte%0d: got %02h required %02h", b, r, e); end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int idle_bad;
      logic [7:0] e, r;
      preload0(); flush0(); push_exp0(9);
      pulse_start(0);
      wait_id0(5'd10, 2000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rst_reach_reg10: got id %0d required 10", id0); end
      tick(30);
      // Now inside data bit 6 of byte 0x0A, which is a 0.
      n_vec++; if (txd_w[0] !== 1'b0) begin n_err++; $display("FAIL rst_pre_txd: got %b required 0", txd_w[0]); end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_vec++; if (txd_w[0] !== 1'b1) begin n_err++; $display("FAIL rst_async_txd: got %b required 1", txd_w[0]); end
      n_vec++; if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL rst_async_busy: got %b required 0", busy_w[0]); end
      n_vec++; if (id0 !== 5'd0) begin n_err++; $display("FAIL rst_async_id: got %0d required 0", id0); end
      n_vec++; if (done_w[0] !== 1'b0) begin n_err++; $display("FAIL rst_async_done: got %b required 0", done_w[0]); end
      tick(3);
      n_vec++; if (rx_q0.size() != 41) begin n_err++; $display("FAIL rst_partial_count: got %0d required 41", rx_q0.size()); end
      for (int b = 0; exp_q0.size() > 0; b++) begin
         e = exp_q0.pop_front();
         n_vec++;
         if (rx_q0.size() == 0) begin n_err++; $display("FAIL rst_partial_byte%0d: got none required %02h", b, e); end
         else begin
            r = rx_q0.pop_front();
            if (r !== e) begin n_err++; $display("FAIL rst_partial_byte%0d: got %02h required %02h", b, r, e); end
         end
      end
      rst_n = 1'b1;
      idle_bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (busy_w[0] !== 1'b0 || txd_w[0] !== 1'b1 || done_w[0] !== 1'b0) idle_bad++;
      end
      n_vec++; if (idle_bad != 0) begin n_err++; $display("FAIL rst_stays_idle: got %0d active cycles required 0", idle_bad); end
      flush0(); push_exp0(31);
      pulse_start(0);
      wait_done(0, 6000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rst_redump_timeout: got no done required done"); end
      tick(2);
      n_vec++; if (busy_len[0] !== FULL_BUSY) begin n_err++; $display("FAIL rst_redump_busy_len: got %0d required %0d", busy_len[0], FULL_BUSY); end
      n_vec++; if (rx_q0.size() != 129) begin n_err++; $display("FAIL rst_redump_count: got %0d required 129", rx_q0.size()); end
      for (int b = 0; exp_q0.size() > 0; b++) begin
         e = exp_q0.pop_front();
         n_vec++;
         if (rx_q0.size() == 0) begin n_err++; $display("FAIL rst_redump_byte%0d: got none required %02h", b, e); end
         else begin
            r = rx_q0.pop_front();
            if (r !== e) begin n_err++; $display("FAIL rst_redump_byte%0d: got %02h required %02h", b, r, e); end
         end
      end
      n_vec++; if (viol[0] != 0) begin n_err++; $display("FAIL final_bit_timing: got %0d violations required 0", viol[0]); end
   endtask

   initial begin
      rst_n = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      for (int i = 0; i < 32; i++) begin
         regs0[i] = 32'd0;
         regs1[i] = 32'd0;
      end
      test_reset();
      test_nominal();
      test_short();
      test_start_while_busy();
      test_back_to_back();
      test_snapshot();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
